// File: rtl/cnn_loader_pkg.sv
// Shared constants for the CNN parameter loader: element widths, derived bank
// geometry and the field offsets of fmap/weight/bias inside one packed bank.
package cnn_loader_pkg;

    localparam int CI      = 1;
    localparam int CO      = 1;
    localparam int KX      = 3;
    localparam int KY      = 3;
    localparam int I_F_BW  = 8;
    localparam int W_BW    = 8;
    localparam int B_BW    = 16;
    localparam int WORD_BW = 8;

    localparam int F_BITS    = CI * KX * KY * I_F_BW;
    localparam int WT_BITS   = CO * CI * KX * KY * W_BW;
    localparam int B_BITS    = CO * B_BW;
    localparam int TOTAL     = F_BITS + WT_BITS + B_BITS;
    localparam int NUM_WORDS = (TOTAL + WORD_BW - 1) / WORD_BW;
    localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // Word-aligned width; bits at or above TOTAL in the top word are dropped.
    localparam int PAD_BITS  = NUM_WORDS * WORD_BW;

    // Field offsets within a packed bank.
    localparam int F_OFF  = 0;
    localparam int WT_OFF = F_BITS;
    localparam int B_OFF  = F_BITS + WT_BITS;

    typedef logic [AW-1:0]      word_addr_t;
    typedef logic [WORD_BW-1:0] word_t;

    // True when the word index addresses a real word of the bank.
    function automatic logic addr_in_range(input word_addr_t addr);
        return ({1'b0, addr} < (AW + 1)'(NUM_WORDS));
    endfunction

endpackage

// File: rtl/cnn_loader_bank.sv
// One packed parameter bank: a TOTAL-bit register written one stream word at a
// time, with a synchronous clear. The caller only asserts we for in-range words.
module cnn_loader_bank
    import cnn_loader_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  word_addr_t       addr,
    input  word_t            data,
    output logic [TOTAL-1:0] bits
);

    logic [TOTAL-1:0]    bits_r;
    logic [PAD_BITS-1:0] pad_s;

    // Merge the incoming word into a word-aligned copy of the bank.
    always_comb begin
        pad_s              = '0;
        pad_s[TOTAL-1:0]   = bits_r;
        if (we) begin
            pad_s[addr * WORD_BW +: WORD_BW] = data;
        end else begin
            pad_s[TOTAL-1:0] = bits_r;
        end
    end

    // Bank storage: clear on reset, otherwise capture the merged word.
    always_ff @(posedge clk) begin
        if (clr) begin
            bits_r <= '0;
        end else if (we) begin
            bits_r <= pad_s[TOTAL-1:0];
        end else begin
            bits_r <= bits_r;
        end
    end

    assign bits = bits_r;

endmodule

// File: rtl/cnn_param_loader.sv
// Double-buffered CNN parameter loader. An addressed word stream fills the write
// bank while the core consumes the read bank through out_valid/out_ready.
// Optional feature macro: CNN_LOADER_COVERAGE_EN (reject frames with unwritten words).
module cnn_param_loader
    import cnn_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AW-1:0]      in_addr,
    input  logic [WORD_BW-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [F_BITS-1:0]  out_fmap,
    output logic [WT_BITS-1:0] out_weight,
    output logic [B_BITS-1:0]  out_bias,
    output logic               err_addr,
    output logic               err_incomplete,
    output logic [15:0]        frame_cnt
);

    logic [1:0]       full_r;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic             err_addr_r;
    logic             err_incomplete_r;
    logic [15:0]      frame_cnt_r;

    logic             accept_s;
    logic             in_range_s;
    logic             last_s;
    logic             release_s;
    logic             commit_s;
    logic             reject_s;
    logic             wr_en_s;
    logic [1:0]       full_set_s;
    logic [1:0]       full_clr_s;
    logic [TOTAL-1:0] bank0_s;
    logic [TOTAL-1:0] bank1_s;
    logic [TOTAL-1:0] rd_vec_s;

    assign in_ready   = !full_r[wr_bank_r];
    assign out_valid  = full_r[rd_bank_r];
    assign accept_s   = in_valid && in_ready;
    assign in_range_s = addr_in_range(in_addr);
    assign last_s     = accept_s && in_last;
    assign release_s  = out_valid && out_ready;
    assign wr_en_s    = accept_s && in_range_s;

`ifdef CNN_LOADER_COVERAGE_EN
    logic [NUM_WORDS-1:0] map_r;
    logic [NUM_WORDS-1:0] cur_bit_s;
    logic                 map_full_s;

    // One-hot map bit for the word currently being accepted.
    always_comb begin
        cur_bit_s = '0;
        if (in_range_s) begin
            cur_bit_s = {{(NUM_WORDS - 1){1'b0}}, 1'b1} << in_addr;
        end else begin
            cur_bit_s = '0;
        end
    end

    assign map_full_s = &(map_r | cur_bit_s);
    assign commit_s   = last_s && map_full_s;
    assign reject_s   = last_s && !map_full_s;

    // Written-word map of the filling frame; restarts on every accepted last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            map_r <= '0;
        end else if (last_s) begin
            map_r <= '0;
        end else if (accept_s) begin
            map_r <= map_r | cur_bit_s;
        end else begin
            map_r <= map_r;
        end
    end
`else
    assign commit_s = last_s;
    assign reject_s = 1'b0;
`endif

    // A commit and a release never target the same bank, so both apply together.
    assign full_set_s = commit_s  ? (wr_bank_r ? 2'b10 : 2'b01) : 2'b00;
    assign full_clr_s = release_s ? (rd_bank_r ? 2'b10 : 2'b01) : 2'b00;

    // Bank ownership, handshake state, error flags and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r           <= 2'b00;
            wr_bank_r        <= 1'b0;
            rd_bank_r        <= 1'b0;
            err_addr_r       <= 1'b0;
            err_incomplete_r <= 1'b0;
            frame_cnt_r      <= 16'd0;
        end else begin
            full_r           <= (full_r | full_set_s) & ~full_clr_s;
            wr_bank_r        <= wr_bank_r ^ commit_s;
            rd_bank_r        <= rd_bank_r ^ release_s;
            err_addr_r       <= err_addr_r | (accept_s && !in_range_s);
            err_incomplete_r <= reject_s;
            frame_cnt_r      <= frame_cnt_r + {15'd0, commit_s};
        end
    end

    cnn_loader_bank u_bank0 (
        .clk  (clk),
        .clr  (reset),
        .we   (wr_en_s && !wr_bank_r),
        .addr (in_addr),
        .data (in_data),
        .bits (bank0_s)
    );

    cnn_loader_bank u_bank1 (
        .clk  (clk),
        .clr  (reset),
        .we   (wr_en_s && wr_bank_r),
        .addr (in_addr),
        .data (in_data),
        .bits (bank1_s)
    );

    // Present the read bank only while it is full; otherwise drive zeros.
    always_comb begin
        rd_vec_s = '0;
        if (out_valid) begin
            rd_vec_s = rd_bank_r ? bank1_s : bank0_s;
        end else begin
            rd_vec_s = '0;
        end
    end

    assign out_fmap       = rd_vec_s[F_OFF  +: F_BITS];
    assign out_weight     = rd_vec_s[WT_OFF +: WT_BITS];
    assign out_bias       = rd_vec_s[B_OFF  +: B_BITS];
    assign err_addr       = err_addr_r;
    assign err_incomplete = err_incomplete_r;
    assign frame_cnt      = frame_cnt_r;

endmodule
